seq_divider_8by4: RTL

SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 30 +++
 rtl/seq_divider_8by4.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the sequential 8-by-4 divider.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = 3;

  // Index of the first restoring step (dividend MSB); counts down to 0.
  localparam logic [CNT_W-1:0] CNT_INIT = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not underflow.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] p_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] p_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;

  // Trial subtraction on the 5-bit shifted remainder. The partial remainder
  // always stays below the divisor, so the result fits back into 4 bits.
  always_comb begin
    trial = {p_in, bit_in};
    diff  = trial - {1'b0, divisor};
    if (trial >= {1'b0, divisor}) begin
      p_out = diff[DIVISOR_W-1:0];
      q_bit = 1'b1;
    end else begin
      p_out = trial[DIVISOR_W-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential unsigned 8-bit by 4-bit restoring divider: one quotient bit per
// cycle, MSB first, with a divide-by-zero shortcut and registered results.
module seq_divider_8by4
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz
);

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] a_q, a_d;        // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]  b_q, b_d;        // latched divisor
  logic [DIVISOR_W-1:0]  p_q, p_d;        // partial remainder
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W-1:0]  step_p;
  logic                  step_q;

  div_step u_step (
    .p_in    (p_q),
    .bit_in  (a_q[DIVIDEND_W-1]),
    .divisor (b_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  // Next-state logic: accept in IDLE, iterate in RUN, publish results on entry to DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = dividend;
          b_d   = divisor;
          p_d   = '0;
          cnt_d = CNT_INIT;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        p_d = step_p;
        a_d = {a_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {a_q[DIVIDEND_W-2:0], step_q};
          remainder_d = step_p;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;

endmodule
